seq_subtractor16: RTL and testbench
===================================

SEQ_SUBTRACTOR16 -- requirements
Module: seq_subtractor16

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width; multiple of 4; only 16 is verified.
REQ-002 SHALL have derived constant SLICES = WIDTH/4: number of 4-bit slices processed, one per cycle.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset; asynchronous, active-high.
REQ-005 START  input  1  request; sampled only on a rising edge where READY=1.
REQ-006 A  input  WIDTH  minuend; captured at accept.
REQ-007 B  input  WIDTH  subtrahend; captured at accept.
REQ-008 BIN  input  1  borrow-in; captured at accept.
REQ-009 READY  output  1  high when idle and able to accept START.
REQ-010 D  output  WIDTH  difference, A - B - BIN mod 2^WIDTH.
REQ-011 BOUT  output  1  unsigned borrow-out: 1 iff A < B + BIN.
REQ-012 OVF  output  1  signed overflow: A[MSB] != B[MSB] and D[MSB] != A[MSB].
REQ-013 ZERO  output  1  1 iff D == 0.
REQ-014 DONE  output  1  one-cycle pulse marking new valid D/BOUT/OVF/ZERO.

Function
REQ-015 States SHALL be IDLE and RUN; READY=1 exactly in IDLE.
REQ-016 Accept: at edge N with START=1 and READY=1, SHALL capture A, B, BIN into working registers, clear the slice index to 0, and enter RUN.
REQ-017 In RUN, at each edge N+k (k=1..SLICES), SHALL compute slice k-1, working bits [4(k-1)+3 : 4(k-1)], with a 4-bit borrow-lookahead.
REQ-018 Slice borrow terms: g = ~a & b, p = ~a | b.
REQ-019 Slice borrows: b1 = g0 | p0&bin; b2 = g1 | p1&g0 | p1&p0&bin; b3 and bout expand likewise; diff bit i = a ^ b ^ borrow_i.
REQ-020 The slice borrow-out SHALL be registered and used as the borrow-in of the next slice.
REQ-021 At edge N+SLICES (N+4 for WIDTH=16), SHALL update D, BOUT, OVF and ZERO together, set DONE=1, and return to IDLE (READY=1).
REQ-022 DONE SHALL be high for exactly one cycle (cleared at edge N+SLICES+1).
REQ-023 D, BOUT, OVF and ZERO SHALL hold their previous values throughout RUN and change only at the final edge of an operation.
REQ-024 START while READY=0 SHALL be ignored and not queued.
REQ-025 START at the edge where DONE is high SHALL be accepted, allowing back-to-back operations every SLICES+1 cycles.
REQ-026 Changes on A, B or BIN after accept SHALL NOT affect the result in progress.

Reset
REQ-027 RST high SHALL immediately force IDLE, READY=1, D=0, BOUT=0, OVF=0, ZERO=0 and DONE=0, and clear all working registers.
REQ-028 RST asserted during RUN SHALL abort the operation; no DONE for it after release.
REQ-029 The first accept SHALL be possible at the first rising edge after RST deasserts.

Structure
REQ-030 A shared package/header SHALL hold the state encodings (IDLE, RUN) and the slice width constant 4.
REQ-031 The 4-bit borrow-lookahead SHALL be a combinational sub-module borrow_lookahead4 (ports a[3:0], b[3:0], bin, d[3:0], bout), instantiated once and time-multiplexed across slices.
REQ-032 The slice index SHALL be a counter of width clog2(SLICES) bits.

Verification
REQ-033 A=0x1234, B=0x0234, BIN=0 -> D=0x1000, BOUT=0, OVF=0, ZERO=0; DONE exactly 4 edges after accept, READY low for those 4 cycles.
REQ-034 A=0x0000, B=0x0001, BIN=0 -> D=0xFFFF, BOUT=1, OVF=0, ZERO=0 (borrow ripples through all 4 slices).
REQ-035 A=0x8000, B=0x0001, BIN=0 -> D=0x7FFF, OVF=1, BOUT=0; then A=0x0005, B=0x0004, BIN=1 accepted on the DONE cycle -> D=0x0000, ZERO=1, BOUT=0.
REQ-036 Second START with A=0xFFFF, B=0x0000 at N+2 during run of 0x1234-0x0234 -> ignored; single DONE at N+4 with D=0x1000.
REQ-037 RST asserted at N+2 mid-run -> outputs 0 and READY=1 immediately; no DONE on the following 6 edges.
REQ-038 Random A/B/BIN (>=10000 ops) -> D, BOUT, OVF and ZERO match the reference model A-B-BIN.

Source files
------------

// File: rtl/seq_subtractor16_pkg.sv
// Shared types and constants for the sequential slice-serial subtractor.
package seq_subtractor16_pkg;

  // Width of one borrow-lookahead slice; operands are consumed this many bits per cycle.
  localparam int unsigned SLICE_W = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/borrow_lookahead4.sv
// 4-bit combinational subtractor slice with borrow-lookahead.
module borrow_lookahead4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] brw;

  // Generate/propagate terms and fully expanded borrows into each bit position.
  always_comb begin
    g      = ~a & b;
    p      = ~a | b;
    brw[0] = bin;
    brw[1] = g[0] | (p[0] & bin);
    brw[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
    brw[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bin);
    bout   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & bin);
    d      = a ^ b ^ brw;
  end

endmodule

// File: rtl/seq_subtractor16.sv
// Slice-serial subtractor: computes A - B - BIN four bits per cycle through one shared
// borrow-lookahead slice, publishing D/BOUT/OVF/ZERO together with a one-cycle DONE.
module seq_subtractor16
  import seq_subtractor16_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic             READY,
  output logic [WIDTH-1:0] D,
  output logic             BOUT,
  output logic             OVF,
  output logic             ZERO,
  output logic             DONE
);

  localparam int unsigned SLICES = WIDTH / SLICE_W;
  localparam int unsigned IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SLICE_W{1'b1}});

  state_t state;
  state_t state_next;

  logic             accept;
  logic             last;
  logic [WIDTH-1:0] a_w;
  logic [WIDTH-1:0] b_w;
  logic [WIDTH-1:0] d_w;
  logic             borrow_w;
  logic [IDX_W-1:0] idx;

  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [SLICE_W-1:0] slice_d;
  logic               slice_bout;
  logic [WIDTH-1:0]   d_next;

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: one RUN cycle per slice, leave after the last slice.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (START) state_next = RUN;
      RUN:     if (last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    READY  = (state == IDLE);
    accept = START && (state == IDLE);
    last   = (idx == LAST_IDX);
  end

  // Select the current slice of the working operands.
  always_comb begin
    a_sh = a_w >> (SLICE_W * idx);
    b_sh = b_w >> (SLICE_W * idx);
  end

  borrow_lookahead4 u_bla (
    .a    (a_sh[SLICE_W-1:0]),
    .b    (b_sh[SLICE_W-1:0]),
    .bin  (borrow_w),
    .d    (slice_d),
    .bout (slice_bout)
  );

  // Merge the freshly computed slice into the partial difference.
  always_comb begin
    d_next = (d_w & ~(SLICE_MASK << (SLICE_W * idx)))
           | (WIDTH'(slice_d) << (SLICE_W * idx));
  end

  // Datapath: capture at accept, one slice per RUN cycle, publish results on the last slice.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_w      <= '0;
      b_w      <= '0;
      d_w      <= '0;
      borrow_w <= 1'b0;
      idx      <= '0;
      D        <= '0;
      BOUT     <= 1'b0;
      OVF      <= 1'b0;
      ZERO     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (accept) begin
        a_w      <= A;
        b_w      <= B;
        borrow_w <= BIN;
        d_w      <= '0;
        idx      <= '0;
      end else if (state == RUN) begin
        d_w      <= d_next;
        borrow_w <= slice_bout;
        idx      <= idx + IDX_W'(1);
        if (last) begin
          D    <= d_next;
          BOUT <= slice_bout;
          OVF  <= (a_w[WIDTH-1] != b_w[WIDTH-1]) && (d_next[WIDTH-1] != a_w[WIDTH-1]);
          ZERO <= (d_next == '0);
          DONE <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_subtractor16.sv
// Scoreboard bench for seq_subtractor16: stimulus pushes expected results, a monitor
// pops and compares on every DONE pulse.
module tb_seq_subtractor16;

  typedef struct packed {
    logic [15:0] d;
    logic        bout;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic        CLK;
  logic        RST;
  logic        START;
  logic [15:0] A;
  logic [15:0] B;
  logic        BIN;
  logic        READY;
  logic [15:0] D;
  logic        BOUT;
  logic        OVF;
  logic        ZERO;
  logic        DONE;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  seq_subtractor16 #(.WIDTH(16)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .A     (A),
    .B     (B),
    .BIN   (BIN),
    .READY (READY),
    .D     (D),
    .BOUT  (BOUT),
    .OVF   (OVF),
    .ZERO  (ZERO),
    .DONE  (DONE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: full-precision subtraction, borrow is the sign of the wide result.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    logic [16:0] w;
    exp_t e;
    w      = {1'b0, a} - {1'b0, b} - {16'b0, bin};
    e.d    = w[15:0];
    e.bout = w[16];
    e.ovf  = (a[15] != b[15]) && (w[15] != a[15]);
    e.zero = (w[15:0] == 16'h0000);
    return e;
  endfunction

  // Monitor: every DONE pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (DONE) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'(D), 32'hffff_ffff);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("d", 32'(D), 32'(e.d));
        chk("bout", 32'(BOUT), 32'(e.bout));
        chk("ovf", 32'(OVF), 32'(e.ovf));
        chk("zero", 32'(ZERO), 32'(e.zero));
      end
    end
  end

  // Wait for READY (bounded), present operands, release START right after the accept edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic bin,
                       input bit push, input exp_t e);
    int n = 0;
    while (!READY && n < 20) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (!READY) chk("ready_timeout", 32'(READY), 32'h1);
    A     = a;
    B     = b;
    BIN   = bin;
    START = 1'b1;
    if (push) sb_q.push_back(e);
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!DONE && n < 20) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk("done_wait", 32'(DONE), 32'h1);
  endtask

  initial begin
    exp_t e;
    RST   = 1'b1;
    START = 1'b0;
    A     = '0;
    B     = '0;
    BIN   = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ready", 32'(READY), 32'h1);
    chk("rst_d", 32'(D), 32'h0);
    chk("rst_flags", {29'b0, BOUT, OVF, ZERO}, 32'h0);
    chk("rst_done", 32'(DONE), 32'h0);
    RST = 1'b0;

    // First accept right after reset release; exact 4-cycle latency and held outputs.
    e = '{d: 16'h1000, bout: 1'b0, ovf: 1'b0, zero: 1'b0};
    issue(16'h1234, 16'h0234, 1'b0, 1'b1, e);
    for (int k = 0; k < 4; k++) begin
      chk("run_ready_low", 32'(READY), 32'h0);
      chk("run_no_done", 32'(DONE), 32'h0);
      chk("run_d_hold", 32'(D), 32'h0);
      @(posedge CLK);
      #1;
    end
    chk("lat_done", 32'(DONE), 32'h1);
    chk("lat_ready", 32'(READY), 32'h1);
    @(posedge CLK);
    #1;
    chk("done_one_cycle", 32'(DONE), 32'h0);

    // START during RUN is ignored: only one DONE, with the original result.
    issue(16'h1234, 16'h0234, 1'b0, 1'b1, e);
    A     = 16'hffff;
    B     = 16'h0000;
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    wait_done();
    @(posedge CLK);
    #1;
    chk("ignored_start_idle", 32'(READY), 32'h1);

    // Borrow ripples through every slice.
    e = '{d: 16'hffff, bout: 1'b1, ovf: 1'b0, zero: 1'b0};
    issue(16'h0000, 16'h0001, 1'b0, 1'b1, e);
    wait_done();

    // Signed overflow, then back-to-back accept on the DONE cycle.
    e = '{d: 16'h7fff, bout: 1'b0, ovf: 1'b1, zero: 1'b0};
    issue(16'h8000, 16'h0001, 1'b0, 1'b1, e);
    wait_done();
    e = '{d: 16'h0000, bout: 1'b0, ovf: 1'b0, zero: 1'b1};
    issue(16'h0005, 16'h0004, 1'b1, 1'b1, e);
    chk("b2b_accepted", 32'(READY), 32'h0);
    wait_done();

    e = '{d: 16'hffff, bout: 1'b1, ovf: 1'b0, zero: 1'b0};
    issue(16'hffff, 16'hffff, 1'b1, 1'b1, e);
    e = '{d: 16'h8000, bout: 1'b1, ovf: 1'b1, zero: 1'b0};
    issue(16'h7fff, 16'hffff, 1'b0, 1'b1, e);
    wait_done();

    // Reset mid-run aborts the operation.
    issue(16'h1234, 16'h0234, 1'b0, 1'b0, e);
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    chk("abort_ready", 32'(READY), 32'h1);
    chk("abort_d", 32'(D), 32'h0);
    chk("abort_flags", {29'b0, BOUT, OVF, ZERO}, 32'h0);
    chk("abort_done", 32'(DONE), 32'h0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge CLK);
      #1;
      chk("abort_no_done", 32'(DONE), 32'h0);
    end

    // Random back-to-back operations against the reference model.
    for (int i = 0; i < 10000; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rbin;
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom);
      issue(ra, rb, rbin, 1'b1, model(ra, rb, rbin));
    end

    for (int n = 0; n < 50 && sb_q.size() != 0; n++) begin
      @(posedge CLK);
      #1;
    end
    chk("drain", 32'(sb_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
